// File: rtl/mc_defs_pkg.sv
// ----------------------------------------------------------------------------
// mc_defs: shared definitions for the multi-cycle MIPS control unit.
//   - opcode / function-field constants for the supported instruction subset
//   - FSM state encoding (visible on the debug 'state' port)
//   - numeric encodings of every datapath control bus
//   - instruction class enum produced by the decoder
// ----------------------------------------------------------------------------
package mc_defs;

    // Opcode field values
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LB    = 6'h20;
    localparam logic [5:0] OP_LH    = 6'h21;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SB    = 6'h28;
    localparam logic [5:0] OP_SH    = 6'h29;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // Function field values (R-type)
    localparam logic [5:0] FN_NOP = 6'h00;
    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;

    // FSM states; values are externally visible on the debug port
    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4
    } state_e;

    // Instruction classes
    typedef enum logic [2:0] {
        CLS_ALU,
        CLS_LOAD,
        CLS_STORE,
        CLS_BRANCH,
        CLS_JAL,
        CLS_JR,
        CLS_NOP,
        CLS_ILLEGAL
    } iclass_e;

    // RegDst
    localparam int REGDST_RT = 0;
    localparam int REGDST_RD = 1;
    localparam int REGDST_RA = 2;

    // RegWriteSel
    localparam int WBSEL_ALU = 0;
    localparam int WBSEL_MEM = 1;
    localparam int WBSEL_PC4 = 2;

    // MemWrite
    localparam int MEMW_NONE = 0;
    localparam int MEMW_WORD = 1;
    localparam int MEMW_HALF = 2;
    localparam int MEMW_BYTE = 3;

    // DataExtOp
    localparam int DEXT_WORD = 0;
    localparam int DEXT_LB   = 2;
    localparam int DEXT_LH   = 4;

    // ALUControl
    localparam int ALU_ADD = 0;
    localparam int ALU_SUB = 1;
    localparam int ALU_OR  = 2;

    // ExtOp
    localparam int EXT_ZERO = 0;
    localparam int EXT_SIGN = 1;
    localparam int EXT_LUI  = 2;

    // ALUSrc
    localparam int ALUSRC_REG = 0;
    localparam int ALUSRC_IMM = 1;

    // nPCSel
    localparam int NPC_PC4    = 0;
    localparam int NPC_BRANCH = 1;
    localparam int NPC_JAL    = 2;
    localparam int NPC_JR     = 3;

    // Classes that continue from EXEC into the MEM state
    function automatic logic needs_mem(input iclass_e cls);
        return (cls == CLS_LOAD) || (cls == CLS_STORE);
    endfunction

endpackage

// File: rtl/mc_decode.sv
// ----------------------------------------------------------------------------
// mc_decode: purely combinational instruction decoder.
//   Maps the IR opcode/function fields to an instruction class and the
//   static (state-independent) datapath control fields. The FSM in the top
//   level decides in which state each field is actually driven.
// Ports:
//   op_i, func_i          opcode and function fields from IR
//   cls_o                 instruction class (CLS_ILLEGAL for undefined codes)
//   reg_dst_o .. rws_o    static control fields, CW bits each
// ----------------------------------------------------------------------------
module mc_decode
    import mc_defs::*;
#(
    parameter int CW = 3
) (
    input  logic [5:0]    op_i,
    input  logic [5:0]    func_i,
    output iclass_e       cls_o,
    output logic [CW-1:0] reg_dst_o,
    output logic [CW-1:0] alu_src_o,
    output logic [CW-1:0] alu_ctrl_o,
    output logic [CW-1:0] ext_op_o,
    output logic [CW-1:0] data_ext_op_o,
    output logic [CW-1:0] mem_write_o,
    output logic [CW-1:0] reg_write_sel_o
);

    always_comb begin
        // Undefined encodings fall through as CLS_ILLEGAL with every field 0,
        // which makes them behave exactly like a nop downstream.
        cls_o           = CLS_ILLEGAL;
        reg_dst_o       = CW'(REGDST_RT);
        alu_src_o       = CW'(ALUSRC_REG);
        alu_ctrl_o      = CW'(ALU_ADD);
        ext_op_o        = CW'(EXT_ZERO);
        data_ext_op_o   = CW'(DEXT_WORD);
        mem_write_o     = CW'(MEMW_NONE);
        reg_write_sel_o = CW'(WBSEL_ALU);

        case (op_i)
            OP_RTYPE: begin
                case (func_i)
                    FN_ADD: begin
                        cls_o     = CLS_ALU;
                        reg_dst_o = CW'(REGDST_RD);
                    end
                    FN_SUB: begin
                        cls_o      = CLS_ALU;
                        reg_dst_o  = CW'(REGDST_RD);
                        alu_ctrl_o = CW'(ALU_SUB);
                    end
                    FN_JR:   cls_o = CLS_JR;
                    FN_NOP:  cls_o = CLS_NOP;
                    default: cls_o = CLS_ILLEGAL;
                endcase
            end
            OP_ORI: begin
                cls_o      = CLS_ALU;
                alu_src_o  = CW'(ALUSRC_IMM);
                alu_ctrl_o = CW'(ALU_OR);
                ext_op_o   = CW'(EXT_ZERO);
            end
            OP_LUI: begin
                // rs is $0 in a lui encoding, so rs + (imm << 16) is the result
                cls_o     = CLS_ALU;
                alu_src_o = CW'(ALUSRC_IMM);
                ext_op_o  = CW'(EXT_LUI);
            end
            OP_JAL: begin
                cls_o           = CLS_JAL;
                reg_dst_o       = CW'(REGDST_RA);
                reg_write_sel_o = CW'(WBSEL_PC4);
            end
            OP_LW, OP_LH, OP_LB: begin
                cls_o           = CLS_LOAD;
                alu_src_o       = CW'(ALUSRC_IMM);
                ext_op_o        = CW'(EXT_SIGN);
                reg_write_sel_o = CW'(WBSEL_MEM);
                if (op_i == OP_LH)
                    data_ext_op_o = CW'(DEXT_LH);
                else if (op_i == OP_LB)
                    data_ext_op_o = CW'(DEXT_LB);
                else
                    data_ext_op_o = CW'(DEXT_WORD);
            end
            OP_SW, OP_SH, OP_SB: begin
                cls_o     = CLS_STORE;
                alu_src_o = CW'(ALUSRC_IMM);
                ext_op_o  = CW'(EXT_SIGN);
                if (op_i == OP_SH)
                    mem_write_o = CW'(MEMW_HALF);
                else if (op_i == OP_SB)
                    mem_write_o = CW'(MEMW_BYTE);
                else
                    mem_write_o = CW'(MEMW_WORD);
            end
            OP_BEQ: begin
                cls_o      = CLS_BRANCH;
                alu_ctrl_o = CW'(ALU_SUB);
                ext_op_o   = CW'(EXT_SIGN);
            end
            default: cls_o = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// ----------------------------------------------------------------------------
// multicycle_ctrl: multi-cycle MIPS control unit.
//   Steps each instruction through FETCH/DECODE/EXEC/MEM/WB, waiting on the
//   instruction/data memory ready handshakes with an optional timeout, and
//   drives the datapath control buses, PC/IR write strobes, a retire pulse
//   and a retired-instruction counter.
// Ports:
//   clk, reset             clock (rising edge), asynchronous active-low reset
//   Op, Func, Zero         IR fields and ALU equality flag
//   imem_ready, dmem_ready memory handshakes
//   imem_req, dmem_req     memory requests
//   IRWrite, PCWrite, RegWrite          write strobes
//   MemWrite .. RegWriteSel             datapath control buses (CW bits)
//   state                  current FSM state (debug)
//   retire, retired_cnt    completion pulse and counter
//   illegal, bus_err       sticky error flags, cleared only by reset
// ----------------------------------------------------------------------------
module multicycle_ctrl
    import mc_defs::*;
#(
    parameter int CW       = 3,
    parameter int WAIT_MAX = 15,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       Op,
    input  logic [5:0]       Func,
    input  logic             Zero,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             imem_req,
    output logic             dmem_req,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             RegWrite,
    output logic [CW-1:0]    MemWrite,
    output logic [CW-1:0]    RegDst,
    output logic [CW-1:0]    ALUSrc,
    output logic [CW-1:0]    ALUControl,
    output logic [CW-1:0]    ExtOp,
    output logic [CW-1:0]    DataExtOp,
    output logic [CW-1:0]    nPCSel,
    output logic [CW-1:0]    RegWriteSel,
    output logic [2:0]       state,
    output logic             retire,
    output logic [CNT_W-1:0] retired_cnt,
    output logic             illegal,
    output logic             bus_err
);

    localparam int WAIT_W = (WAIT_MAX > 1) ? $clog2(WAIT_MAX + 1) : 1;

    // ------------------------------------------------------------------
    // Decoder
    // ------------------------------------------------------------------
    iclass_e       cls;
    logic [CW-1:0] dec_reg_dst;
    logic [CW-1:0] dec_alu_src;
    logic [CW-1:0] dec_alu_ctrl;
    logic [CW-1:0] dec_ext_op;
    logic [CW-1:0] dec_data_ext_op;
    logic [CW-1:0] dec_mem_write;
    logic [CW-1:0] dec_reg_write_sel;

    mc_decode #(.CW(CW)) u_decode (
        .op_i            (Op),
        .func_i          (Func),
        .cls_o           (cls),
        .reg_dst_o       (dec_reg_dst),
        .alu_src_o       (dec_alu_src),
        .alu_ctrl_o      (dec_alu_ctrl),
        .ext_op_o        (dec_ext_op),
        .data_ext_op_o   (dec_data_ext_op),
        .mem_write_o     (dec_mem_write),
        .reg_write_sel_o (dec_reg_write_sel)
    );

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e             state_q,   state_d;
    logic [WAIT_W-1:0]  wait_q,    wait_d;
    logic [CNT_W-1:0]   retired_q, retired_d;
    logic               illegal_q, illegal_d;
    logic               bus_err_q, bus_err_d;

    // Ungated FSM outputs; forced to 0 while reset is held
    logic          imem_req_r;
    logic          dmem_req_r;
    logic          ir_write_r;
    logic          reg_write_r;
    logic [CW-1:0] mem_write_r;
    logic [CW-1:0] npc_sel_r;
    logic          fin;          // final cycle of a completed instruction
    logic          abort;        // ready timeout in FETCH or MEM
    logic          timeout_hit;

    // ------------------------------------------------------------------
    // Ready-wait counter: counts stalled cycles in FETCH/MEM and clears
    // whenever the FSM moves on (including FETCH -> FETCH after an abort).
    // ------------------------------------------------------------------
    generate
        if (WAIT_MAX > 0) begin : g_timeout
            logic waiting;
            assign waiting = ((state_q == ST_FETCH) && !imem_ready) ||
                             ((state_q == ST_MEM)   && !dmem_ready);

            always_comb begin
                wait_d = '0;
                if (waiting && !abort)
                    wait_d = wait_q + WAIT_W'(1);
            end

            assign timeout_hit = (wait_q == WAIT_W'(WAIT_MAX));
        end else begin : g_no_timeout
            assign wait_d      = '0;
            assign timeout_hit = 1'b0;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Next-state and control logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        imem_req_r  = 1'b0;
        dmem_req_r  = 1'b0;
        ir_write_r  = 1'b0;
        reg_write_r = 1'b0;
        mem_write_r = '0;
        npc_sel_r   = CW'(NPC_PC4);
        fin         = 1'b0;
        abort       = 1'b0;

        case (state_q)
            ST_FETCH: begin
                imem_req_r = 1'b1;
                // A ready in the timeout cycle still wins over the abort
                if (imem_ready) begin
                    ir_write_r = 1'b1;
                    state_d    = ST_DECODE;
                end else if (timeout_hit) begin
                    abort = 1'b1;
                end
            end
            ST_DECODE: begin
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                if (needs_mem(cls)) begin
                    state_d = ST_MEM;
                end else begin
                    case (cls)
                        CLS_ALU, CLS_JAL: state_d = ST_WB;
                        CLS_BRANCH: begin
                            fin       = 1'b1;
                            npc_sel_r = Zero ? CW'(NPC_BRANCH) : CW'(NPC_PC4);
                        end
                        CLS_JR: begin
                            fin       = 1'b1;
                            npc_sel_r = CW'(NPC_JR);
                        end
                        // nop and illegal retire here with a plain PC+4
                        default: fin = 1'b1;
                    endcase
                end
            end
            ST_MEM: begin
                dmem_req_r  = 1'b1;
                mem_write_r = dec_mem_write;  // non-zero only for stores
                if (dmem_ready) begin
                    if (cls == CLS_LOAD)
                        state_d = ST_WB;
                    else
                        fin = 1'b1;
                end else if (timeout_hit) begin
                    abort = 1'b1;
                end
            end
            ST_WB: begin
                reg_write_r = 1'b1;
                fin         = 1'b1;
                if (cls == CLS_JAL)
                    npc_sel_r = CW'(NPC_JAL);
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase

        // Completion and abort both advance the PC and restart fetch; an
        // abort keeps nPCSel at PC+4 and writes nothing else.
        if (fin || abort)
            state_d = ST_FETCH;
    end

    always_comb begin
        illegal_d = illegal_q | ((state_q == ST_DECODE) && (cls == CLS_ILLEGAL));
        bus_err_d = bus_err_q | abort;
        retired_d = fin ? retired_q + CNT_W'(1) : retired_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_FETCH;
            wait_q    <= '0;
            retired_q <= '0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            retired_q <= retired_d;
            illegal_q <= illegal_d;
            bus_err_q <= bus_err_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs. Operand/ALU fields stay valid from EXEC through WB because
    // the datapath has no ALU output register; write-back fields only in WB.
    // Everything is forced low while reset is asserted.
    // ------------------------------------------------------------------
    logic alu_phase;
    logic wb_phase;

    assign alu_phase = reset && ((state_q == ST_EXEC) || (state_q == ST_MEM) ||
                                 (state_q == ST_WB));
    assign wb_phase  = reset && (state_q == ST_WB);

    assign imem_req    = reset & imem_req_r;
    assign dmem_req    = reset & dmem_req_r;
    assign IRWrite     = reset & ir_write_r;
    assign PCWrite     = reset & (fin | abort);
    assign RegWrite    = reset & reg_write_r;
    assign retire      = reset & fin;
    assign MemWrite    = reset     ? mem_write_r       : '0;
    assign nPCSel      = reset     ? npc_sel_r         : '0;
    assign ALUSrc      = alu_phase ? dec_alu_src       : '0;
    assign ALUControl  = alu_phase ? dec_alu_ctrl      : '0;
    assign ExtOp       = alu_phase ? dec_ext_op        : '0;
    assign RegDst      = wb_phase  ? dec_reg_dst       : '0;
    assign DataExtOp   = wb_phase  ? dec_data_ext_op   : '0;
    assign RegWriteSel = wb_phase  ? dec_reg_write_sel : '0;

    assign state       = state_q;
    assign retired_cnt = retired_q;
    assign illegal     = illegal_q;
    assign bus_err     = bus_err_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// ----------------------------------------------------------------------------
// Bench for multicycle_ctrl: directed cases followed by random instructions
// with random memory latencies, each cycle compared against expectations
// built from an instruction table and the per-class state path.
// ----------------------------------------------------------------------------
module tb_multicycle_ctrl;

    localparam int CW       = 3;
    localparam int WAIT_MAX = 15;
    localparam int CNT_W    = 32;

    // Instruction kinds (which states the instruction visits)
    localparam int K_WB  = 0;   // EXEC -> WB
    localparam int K_LD  = 1;   // EXEC -> MEM -> WB
    localparam int K_ST  = 2;   // EXEC -> MEM (final)
    localparam int K_BEQ = 3;   // EXEC final
    localparam int K_JR  = 4;
    localparam int K_NOP = 5;
    localparam int K_ILL = 6;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [5:0]       Op = '0;
    logic [5:0]       Func = '0;
    logic             Zero = 1'b0;
    logic             imem_ready = 1'b0;
    logic             dmem_ready = 1'b0;
    logic             imem_req, dmem_req, IRWrite, PCWrite, RegWrite;
    logic [CW-1:0]    MemWrite, RegDst, ALUSrc, ALUControl, ExtOp, DataExtOp, nPCSel, RegWriteSel;
    logic [2:0]       state;
    logic             retire;
    logic [CNT_W-1:0] retired_cnt;
    logic             illegal, bus_err;

    multicycle_ctrl #(.CW(CW), .WAIT_MAX(WAIT_MAX), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .Op(Op), .Func(Func), .Zero(Zero),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .imem_req(imem_req), .dmem_req(dmem_req), .IRWrite(IRWrite),
        .PCWrite(PCWrite), .RegWrite(RegWrite), .MemWrite(MemWrite),
        .RegDst(RegDst), .ALUSrc(ALUSrc), .ALUControl(ALUControl),
        .ExtOp(ExtOp), .DataExtOp(DataExtOp), .nPCSel(nPCSel),
        .RegWriteSel(RegWriteSel), .state(state), .retire(retire),
        .retired_cnt(retired_cnt), .illegal(illegal), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    logic [32:0] obs;
    assign obs = {state, imem_req, dmem_req, IRWrite, PCWrite, RegWrite, retire,
                  MemWrite, RegDst, ALUSrc, ALUControl, ExtOp, DataExtOp, nPCSel, RegWriteSel};

    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        int         kind;
        int         rd, asrc, actl, ex, de, mw, rs;
        bit         jal;
    } row_t;

    row_t  tbl[16];
    string names[16];

    int               n_vec = 0;
    int               n_bad = 0;
    logic [CNT_W-1:0] ret_m = '0;
    bit               ill_m = 1'b0;
    bit               bus_m = 1'b0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic set_row(input int i, input string nm, input logic [5:0] op, input logic [5:0] fn,
                           input int kind, input int rd, input int asrc, input int actl,
                           input int ex, input int de, input int mw, input int rs, input bit jal);
        names[i]     = nm;
        tbl[i].op    = op;   tbl[i].fn   = fn;   tbl[i].kind = kind;
        tbl[i].rd    = rd;   tbl[i].asrc = asrc; tbl[i].actl = actl;
        tbl[i].ex    = ex;   tbl[i].de   = de;   tbl[i].mw   = mw;
        tbl[i].rs    = rs;   tbl[i].jal  = jal;
    endtask

    // {state, imem_req, dmem_req, IRWrite, PCWrite, RegWrite, retire, MemWrite,
    //  RegDst, ALUSrc, ALUControl, ExtOp, DataExtOp, nPCSel, RegWriteSel}
    function automatic logic [32:0] mkexp(input int st, input bit imr, input bit dmr, input bit irw,
                                          input bit pcw, input bit rw, input bit ret,
                                          input int mw, input int rd, input int asrc, input int actl,
                                          input int ex, input int de, input int np, input int rs);
        return {st[2:0], imr, dmr, irw, pcw, rw, ret, mw[2:0], rd[2:0], asrc[2:0],
                actl[2:0], ex[2:0], de[2:0], np[2:0], rs[2:0]};
    endfunction

    // Called at posedge+1 with inputs already driven; compares at negedge.
    task automatic cycle(input logic [32:0] e, input string nm);
        @(negedge clk);
        check({nm, "/state"},   64'(obs[32:30]), 64'(e[32:30]));
        check({nm, "/strobes"}, 64'(obs[29:24]), 64'(e[29:24]));
        check({nm, "/ctl"},     64'(obs[23:0]),  64'(e[23:0]));
        @(posedge clk);
        #1;
    endtask

    // One instruction: di/dd = cycles of ready low before it rises in
    // FETCH/MEM; rst_at >= 0 asserts reset in that MEM cycle instead.
    task automatic run_instr(input int idx, input int di, input int dd, input bit zv, input int rst_at);
        row_t r;
        bit   aborted, rdy, fin;
        int   ncyc, np;
        r       = tbl[idx];
        aborted = 1'b0;
        ncyc    = 0;
        Op      = r.op;
        Func    = (idx == 14) ? 6'($urandom) : r.fn;
        Zero    = zv;

        for (int k = 0; k <= WAIT_MAX; k++) begin
            rdy        = (k >= di);
            imem_ready = rdy;
            dmem_ready = 1'($urandom);
            aborted    = !rdy && (k == WAIT_MAX);
            cycle(mkexp(0, 1, 0, rdy, aborted, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "fetch");
            ncyc++;
            if (rdy || aborted) break;
        end

        if (aborted) begin
            bus_m = 1'b1;
        end else begin
            imem_ready = 1'($urandom);
            dmem_ready = 1'($urandom);
            cycle(mkexp(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "decode");
            ncyc++;
            if (r.kind == K_ILL) ill_m = 1'b1;

            fin = (r.kind == K_BEQ) || (r.kind == K_JR) || (r.kind == K_NOP) || (r.kind == K_ILL);
            np  = (r.kind == K_BEQ) ? int'(zv) : ((r.kind == K_JR) ? 3 : 0);
            imem_ready = 1'($urandom);
            dmem_ready = 1'($urandom);
            cycle(mkexp(2, 0, 0, 0, fin, 0, fin, 0, 0, r.asrc, r.actl, r.ex, 0, fin ? np : 0, 0), "exec");
            ncyc++;
            if (fin) ret_m++;

            if ((r.kind == K_LD) || (r.kind == K_ST)) begin
                for (int k = 0; k <= WAIT_MAX; k++) begin
                    rdy        = (k >= dd);
                    imem_ready = 1'($urandom);
                    if (rst_at >= 0 && k == rst_at) begin
                        dmem_ready = 1'b0;
                        reset      = 1'b0;
                        #1;
                        check("reset_outputs", 64'(obs), 64'(0));
                        check("reset_cnt", 64'(retired_cnt), 64'(0));
                        check("reset_flags", 64'({illegal, bus_err}), 64'(0));
                        ret_m = '0;
                        ill_m = 1'b0;
                        bus_m = 1'b0;
                        @(posedge clk);
                        #1;
                        reset = 1'b1;
                        $display("instr %-4s reset asserted in MEM cycle %0d", names[idx], k);
                        return;
                    end
                    dmem_ready = rdy;
                    aborted    = !rdy && (k == WAIT_MAX);
                    fin        = rdy && (r.kind == K_ST);
                    cycle(mkexp(3, 0, 1, 0, fin || aborted, 0, fin, r.mw, 0, r.asrc, r.actl, r.ex, 0, 0, 0), "mem");
                    ncyc++;
                    if (fin) ret_m++;
                    if (rdy || aborted) break;
                end
                if (aborted) bus_m = 1'b1;
            end

            if ((r.kind == K_WB) || ((r.kind == K_LD) && !aborted)) begin
                imem_ready = 1'($urandom);
                dmem_ready = 1'($urandom);
                cycle(mkexp(4, 0, 0, 0, 1, 1, 1, 0, r.rd, r.asrc, r.actl, r.ex, r.de,
                            r.jal ? 2 : 0, r.rs), "wb");
                ncyc++;
                ret_m++;
            end
        end

        check("retired_cnt", 64'(retired_cnt), 64'(ret_m));
        check("illegal", 64'(illegal), 64'(ill_m));
        check("bus_err", 64'(bus_err), 64'(bus_m));
        $display("instr %-4s op=%02h di=%0d dd=%0d zero=%0d cycles=%0d aborted=%0d retired=%0d",
                 names[idx], Op, di, dd, zv, ncyc, aborted, retired_cnt);
    endtask

    function automatic int rand_delay();
        return ($urandom_range(0, 9) == 0) ? int'($urandom_range(13, 18)) : int'($urandom_range(0, 2));
    endfunction

    initial begin
        //              name   op     fn     kind   rd asrc actl ex de mw rs jal
        set_row(0,  "add",  6'h00, 6'h20, K_WB,  1, 0, 0, 0, 0, 0, 0, 0);
        set_row(1,  "sub",  6'h00, 6'h22, K_WB,  1, 0, 1, 0, 0, 0, 0, 0);
        set_row(2,  "ori",  6'h0D, 6'h00, K_WB,  0, 1, 2, 0, 0, 0, 0, 0);
        set_row(3,  "lui",  6'h0F, 6'h00, K_WB,  0, 1, 0, 2, 0, 0, 0, 0);
        set_row(4,  "jal",  6'h03, 6'h00, K_WB,  2, 0, 0, 0, 0, 0, 2, 1);
        set_row(5,  "lw",   6'h23, 6'h00, K_LD,  0, 1, 0, 1, 0, 0, 1, 0);
        set_row(6,  "lh",   6'h21, 6'h00, K_LD,  0, 1, 0, 1, 4, 0, 1, 0);
        set_row(7,  "lb",   6'h20, 6'h00, K_LD,  0, 1, 0, 1, 2, 0, 1, 0);
        set_row(8,  "sw",   6'h2B, 6'h00, K_ST,  0, 1, 0, 1, 0, 1, 0, 0);
        set_row(9,  "sh",   6'h29, 6'h00, K_ST,  0, 1, 0, 1, 0, 2, 0, 0);
        set_row(10, "sb",   6'h28, 6'h00, K_ST,  0, 1, 0, 1, 0, 3, 0, 0);
        set_row(11, "beq",  6'h04, 6'h00, K_BEQ, 0, 0, 1, 1, 0, 0, 0, 0);
        set_row(12, "jr",   6'h00, 6'h08, K_JR,  0, 0, 0, 0, 0, 0, 0, 0);
        set_row(13, "nop",  6'h00, 6'h00, K_NOP, 0, 0, 0, 0, 0, 0, 0, 0);
        set_row(14, "ill",  6'h3F, 6'h00, K_ILL, 0, 0, 0, 0, 0, 0, 0, 0);
        set_row(15, "illr", 6'h00, 6'h3F, K_ILL, 0, 0, 0, 0, 0, 0, 0, 0);

        // Reset state: outputs low even though FETCH would request and ready is high
        imem_ready = 1'b1;
        dmem_ready = 1'b1;
        Op         = 6'h23;
        #3;
        check("por_outputs", 64'(obs), 64'(0));
        check("por_cnt", 64'(retired_cnt), 64'(0));
        check("por_flags", 64'({illegal, bus_err}), 64'(0));
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Directed cases
        run_instr(0,  0,  0, 1'b0, -1);   // add, 4 cycles
        run_instr(5,  0,  3, 1'b0, -1);   // lw, MEM held 4 cycles
        run_instr(10, 1,  2, 1'b0, -1);   // sb
        run_instr(11, 0,  0, 1'b1, -1);   // beq taken
        run_instr(11, 0,  0, 1'b0, -1);   // beq not taken
        run_instr(0,  40, 0, 1'b0, -1);   // fetch timeout
        run_instr(1,  0,  0, 1'b0, -1);   // normal fetch after abort
        run_instr(14, 0,  0, 1'b0, -1);   // illegal opcode
        run_instr(4,  15, 0, 1'b0, -1);   // ready in the timeout cycle wins
        run_instr(8,  0,  15, 1'b0, -1);  // same boundary in MEM
        run_instr(6,  0,  16, 1'b0, -1);  // MEM timeout on a load
        run_instr(12, 0,  0, 1'b0, -1);   // jr
        run_instr(13, 0,  0, 1'b0, -1);   // nop

        for (int n = 0; n < 150; n++)
            run_instr(int'($urandom_range(0, 15)), rand_delay(), rand_delay(), 1'($urandom), -1);

        run_instr(9, 0, 10, 1'b0, 3);     // reset in the middle of MEM
        run_instr(0, 0, 0, 1'b0, -1);     // clean operation after reset

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
